// File: rtl/alu_mc_if.sv
// Control-unit <-> multi-cycle ALU bus: start/busy/done handshake,
// operands and registered result with NZCV flags.
interface alu_mc_if #(
   parameter int N = 64
);
   logic         start;
   logic [3:0]   ALUControl;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] result;
   logic         zero;
   logic         negative;
   logic         carry;
   logic         overflow;
   logic         busy;
   logic         done;

   modport master (
      output start, ALUControl, a, b,
      input  result, zero, negative, carry, overflow, busy, done
   );

   modport slave (
      input  start, ALUControl, a, b,
      output result, zero, negative, carry, overflow, busy, done
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle AND/OR/ADD/SUB/PASS_B/NOR/LSL plus iterative
// unsigned shift-add MUL and restoring UDIV, one bit per cycle.
module alu_mc #(
   parameter int N = 64
) (
   input logic     clk,
   input logic     reset,
   alu_mc_if.slave bus
);
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_UDIV = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_LSL0 = 4'b1000;
   localparam logic [3:0] OP_LSL1 = 4'b1001;
   localparam logic [3:0] OP_LSL2 = 4'b1010;
   localparam logic [3:0] OP_LSL3 = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ITER = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_is_div;
   logic [N-1:0]  r_p;
   logic [N-1:0]  r_q;
   logic [N-1:0]  r_m;
   logic [N-1:0]  r_result;
   logic          r_zero;
   logic          r_negative;
   logic          r_carry;
   logic          r_overflow;
   logic          r_busy;
   logic          r_done;

   logic          w_accept;
   logic          w_iter_op;
   logic          w_last;
   logic          w_busy_nxt;
   logic          w_done_nxt;
   logic [N:0]    w_add;
   logic [N:0]    w_sub;
   logic [5:0]    w_lsl_sh;
   logic [N-1:0]  w_sc_res;
   logic          w_sc_c;
   logic          w_sc_v;
   logic [N-1:0]  w_mul_acc;
   logic [N:0]    w_div_sh;
   logic [N:0]    w_div_diff;
   logic          w_div_ge;
   logic [N-1:0]  w_div_rem;
   logic [N-1:0]  w_div_q;
   logic [N-1:0]  w_res_nxt;
   logic          w_c_nxt;
   logic          w_v_nxt;

   assign w_accept  = bus.start && (r_state != S_ITER);
   assign w_iter_op = (bus.ALUControl == OP_MUL) ||
                      ((bus.ALUControl == OP_UDIV) && (bus.b != {N{1'b0}}));
   assign w_last    = (r_cnt == CNT_ONE);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: accept from IDLE or DONE, leave ITER after the last step.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               if (w_iter_op) begin
                  w_state_nxt = S_ITER;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ITER: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_ITER;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the upcoming state, registered below.
   always_comb begin
      w_busy_nxt = (w_state_nxt == S_ITER);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   // Single-cycle operations straight from the bus operands.
   always_comb begin
      w_add    = {1'b0, bus.a} + {1'b0, bus.b};
      w_sub    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
      w_lsl_sh = {bus.ALUControl[1:0], 4'b0000};
      w_sc_res = {N{1'b0}};
      w_sc_c   = 1'b0;
      w_sc_v   = 1'b0;
      case (bus.ALUControl)
         OP_AND:  w_sc_res = bus.a & bus.b;
         OP_OR:   w_sc_res = bus.a | bus.b;
         OP_ADD: begin
            w_sc_res = w_add[N-1:0];
            w_sc_c   = w_add[N];
            w_sc_v   = (bus.a[N-1] == bus.b[N-1]) && (w_add[N-1] != bus.a[N-1]);
         end
         OP_SUB: begin
            w_sc_res = w_sub[N-1:0];
            w_sc_c   = w_sub[N];
            w_sc_v   = (bus.a[N-1] != bus.b[N-1]) && (w_sub[N-1] != bus.a[N-1]);
         end
         OP_PASS: w_sc_res = bus.b;
         OP_NOR:  w_sc_res = ~(bus.a | bus.b);
         OP_LSL0, OP_LSL1, OP_LSL2, OP_LSL3: w_sc_res = bus.b << w_lsl_sh;
         // UDIV reaches here only with b == 0 and yields 0.
         default: w_sc_res = {N{1'b0}};
      endcase
   end

   // One MUL shift-add step and one restoring UDIV step.
   always_comb begin
      w_mul_acc  = r_q[0] ? (r_p + r_m) : r_p;
      w_div_sh   = {r_p, r_q[N-1]};
      w_div_diff = w_div_sh - {1'b0, r_m};
      w_div_ge   = ~w_div_diff[N];
      w_div_rem  = w_div_ge ? w_div_diff[N-1:0] : w_div_sh[N-1:0];
      w_div_q    = {r_q[N-2:0], w_div_ge};
   end

   // Value committed on entry to DONE.
   always_comb begin
      if (r_state == S_ITER) begin
         w_res_nxt = r_is_div ? w_div_q : w_mul_acc;
         w_c_nxt   = 1'b0;
         w_v_nxt   = 1'b0;
      end else begin
         w_res_nxt = w_sc_res;
         w_c_nxt   = w_sc_c;
         w_v_nxt   = w_sc_v;
      end
   end

   // Iteration registers: r_p acc/remainder, r_q multiplier/quotient, r_m multiplicand/divisor.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= {CW{1'b0}};
         r_is_div <= 1'b0;
         r_p      <= {N{1'b0}};
         r_q      <= {N{1'b0}};
         r_m      <= {N{1'b0}};
      end else if (w_accept && w_iter_op) begin
         r_cnt    <= CNT_INIT;
         r_is_div <= (bus.ALUControl == OP_UDIV);
         r_p      <= {N{1'b0}};
         if (bus.ALUControl == OP_UDIV) begin
            r_q <= bus.a;
            r_m <= bus.b;
         end else begin
            r_q <= bus.b;
            r_m <= bus.a;
         end
      end else if (r_state == S_ITER) begin
         r_cnt <= r_cnt - CNT_ONE;
         if (r_is_div) begin
            r_p <= w_div_rem;
            r_q <= w_div_q;
         end else begin
            r_p <= w_mul_acc;
            r_q <= {1'b0, r_q[N-1:1]};
            r_m <= {r_m[N-2:0], 1'b0};
         end
      end
   end

   // Registered result, flags and handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result   <= {N{1'b0}};
         r_zero     <= 1'b1;
         r_negative <= 1'b0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         if (w_done_nxt) begin
            r_result   <= w_res_nxt;
            r_zero     <= (w_res_nxt == {N{1'b0}});
            r_negative <= w_res_nxt[N-1];
            r_carry    <= w_c_nxt;
            r_overflow <= w_v_nxt;
         end
      end
   end

   assign bus.result   = r_result;
   assign bus.zero     = r_zero;
   assign bus.negative = r_negative;
   assign bus.carry    = r_carry;
   assign bus.overflow = r_overflow;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, multi-cycle corner sequences and
// randomized ops against a plain-arithmetic reference model (N=64 and N=16).
module tb_alu_mc;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   alu_mc_if #(.N(64)) bus ();
   alu_mc_if #(.N(16)) bus16 ();

   alu_mc #(.N(64)) dut (.clk(clk), .reset(reset), .bus(bus));
   alu_mc #(.N(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
      int          lat;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input string what, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s %s: got 0x%0h, expected 0x%0h", name, what, act, exp);
      end
   endtask

   // Reference model straight from the operation definitions.
   function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic c, output logic v);
      logic signed [64:0] s;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin
            r = a + b;
            c = (r < a);
            s = $signed({a[63], a}) + $signed({b[63], b});
            v = (s[64] != s[63]);
         end
         4'b0110: begin
            r = a - b;
            c = (a >= b);
            s = $signed({a[63], a}) - $signed({b[63], b});
            v = (s[64] != s[63]);
         end
         4'b0111: r = b;
         4'b1100: r = ~(a | b);
         4'b1000, 4'b1001, 4'b1010, 4'b1011: r = b << (16 * int'(op[1:0]));
         4'b0011: r = a * b;
         4'b0100: r = (b == 64'd0) ? 64'd0 : a / b;
         default: r = 64'd0;
      endcase
   endfunction

   task automatic run_check(input string name, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] r, input logic z, input logic n, input logic c, input logic v,
                            input int elat, input int inj);
      int lat;
      int bc;
      lat = 0;
      bc  = 0;
      bus.ALUControl = op;
      bus.a          = a;
      bus.b          = b;
      bus.start      = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         bus.start      = (lat == inj);
         bus.ALUControl = (lat == inj) ? 4'b0010 : 4'($urandom_range(0, 15));
         bus.a          = {$urandom, $urandom};
         bus.b          = {$urandom, $urandom};
         if (bus.busy === 1'b1) bc++;
      end while (bus.done !== 1'b1 && lat < 200);
      chk(name, "latency", 64'(lat), 64'(elat));
      chk(name, "busy_cycles", 64'(bc), 64'(elat - 1));
      chk(name, "busy_at_done", 64'(bus.busy), 64'd0);
      chk(name, "result", bus.result, r);
      chk(name, "nzcv", {60'd0, bus.negative, bus.zero, bus.carry, bus.overflow}, {60'd0, n, z, c, v});
      @(negedge clk);
      chk(name, "done_pulse_end", 64'(bus.done), 64'd0);
      chk(name, "result_held", bus.result, r);
   endtask

   task automatic run16(input string name, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input int elat);
      int lat;
      lat = 0;
      bus16.ALUControl = op;
      bus16.a          = a;
      bus16.b          = b;
      bus16.start      = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         bus16.start = 1'b0;
      end while (bus16.done !== 1'b1 && lat < 100);
      chk(name, "latency", 64'(lat), 64'(elat));
      chk(name, "result", 64'(bus16.result), 64'(r));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  op;
      logic [63:0] ra;
      logic [63:0] rb;
      logic [63:0] er;
      logic        ec;
      logic        ev;
      int          el;
      int          ndone;

      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.start = 1'b0;   bus.ALUControl = 4'd0;   bus.a = 64'd0;   bus.b = 64'd0;
      bus16.start = 1'b0; bus16.ALUControl = 4'd0; bus16.a = 16'd0; bus16.b = 16'd0;

      tbl[0]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
      tbl[1]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1};
      tbl[2]  = '{4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      tbl[3]  = '{4'b1010, 64'd0, 64'hABCD, 64'h0000_ABCD_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[4]  = '{4'b1011, 64'd0, 64'h1_0000, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[5]  = '{4'b0011, 64'd12345, 64'd678, 64'd8369910, 1'b0, 1'b0, 1'b0, 1'b0, 65};
      tbl[6]  = '{4'b0100, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 1'b0, 1'b0, 65};
      tbl[7]  = '{4'b0100, 64'd100, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[8]  = '{4'b0000, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h000F_000F_000F_000F, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[9]  = '{4'b0001, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0FFF_0FFF_0FFF_0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[10] = '{4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      tbl[11] = '{4'b0111, 64'd5, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      tbl[12] = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
      tbl[13] = '{4'b1111, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[14] = '{4'b1000, 64'd0, 64'h1234, 64'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[15] = '{4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b0, 1'b0, 65};
      tbl[16] = '{4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 65};
      tbl[17] = '{4'b0110, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1};

      repeat (3) @(negedge clk);
      chk("reset", "result", bus.result, 64'd0);
      chk("reset", "nzcv", {60'd0, bus.negative, bus.zero, bus.carry, bus.overflow}, 64'h4);
      chk("reset", "busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                   tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v, tbl[i].lat, -1);
      end

      // A start with another op during the MUL must be ignored.
      run_check("mul_ignore", 4'b0011, 64'd12345, 64'd678, 64'd8369910, 1'b0, 1'b0, 1'b0, 1'b0, 65, 20);

      // Back-to-back single-cycle ops with start held high.
      bus.ALUControl = 4'b0010; bus.a = 64'd1; bus.b = 64'd1; bus.start = 1'b1;
      @(negedge clk);
      chk("b2b", "done1", 64'(bus.done), 64'd1);
      chk("b2b", "result1", bus.result, 64'd2);
      bus.ALUControl = 4'b0110; bus.a = 64'd10; bus.b = 64'd3;
      @(negedge clk);
      chk("b2b", "done2", 64'(bus.done), 64'd1);
      chk("b2b", "result2", bus.result, 64'd7);
      chk("b2b", "carry2", 64'(bus.carry), 64'd1);
      bus.start = 1'b0;
      @(negedge clk);
      chk("b2b", "done3", 64'(bus.done), 64'd0);

      // Reset in the middle of a MUL aborts it without a done.
      bus.ALUControl = 4'b0011; bus.a = 64'd99; bus.b = 64'd77; bus.start = 1'b1;
      repeat (30) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk("abort", "busy_before", 64'(bus.busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("abort", "result", bus.result, 64'd0);
      chk("abort", "nzcv", {60'd0, bus.negative, bus.zero, bus.carry, bus.overflow}, 64'h4);
      chk("abort", "busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      end
      chk("abort", "no_done_or_busy", 64'(ndone), 64'd0);
      run_check("after_abort_add", 4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1);

      run16("n16_div", 4'b0100, 16'hFFFF, 16'h0001, 16'hFFFF, 17);
      run16("n16_mul", 4'b0011, 16'hFFFF, 16'hFFFF, 16'h0001, 17);
      run16("n16_lsl", 4'b1001, 16'd0, 16'h00AB, 16'h0000, 1);

      for (int i = 0; i < 200; i++) begin
         op = 4'($urandom_range(0, 15));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: ra = 64'($urandom_range(0, 999));
            1: rb = 64'($urandom_range(0, 20));
            2: rb = ra;
            default: ;
         endcase
         if (op == 4'b0011 && rb == 64'd0) rb = 64'd1;
         model(op, ra, rb, er, ec, ev);
         el = (op == 4'b0011 || (op == 4'b0100 && rb != 64'd0)) ? 65 : 1;
         run_check($sformatf("rnd%0d_op%0h", i, op), op, ra, rb, er, (er == 64'd0), er[63], ec, ev, el, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
